// File: rtl/dense_to_coo_encoder_if.sv
// Dense-row input, COO-entry output and per-matrix status of the dense-to-COO encoder.
// The encoder takes the slave modport; the row source and entry consumer take the master.
interface dense_to_coo_encoder_if #(
  parameter int N       = 8,
  parameter int MAX_NNZ = 32
);
  localparam int ROW_W = $clog2(N);
  localparam int IDX_W = $clog2(MAX_NNZ);

  logic                in_valid;
  logic                in_ready;
  logic [8*N-1:0]      in_row;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_data;
  logic [ROW_W-1:0]    out_row;
  logic [ROW_W-1:0]    out_col;
  logic [IDX_W-1:0]    out_idx;
  logic                done;
  logic [IDX_W:0]      nnz_count;
  logic                overflow;

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_idx,
           done, nnz_count, overflow
  );

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_idx,
           done, nnz_count, overflow
  );
endinterface

// File: rtl/dense_to_coo_encoder.sv
// Compresses a dense NxN E4M3 matrix, one row per beat, into a row-major COO entry stream.
// Zeros (+0 and -0) are dropped; entries past MAX_NNZ are scanned but suppressed.
module dense_to_coo_encoder #(
  parameter int N       = 8,
  parameter int MAX_NNZ = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  dense_to_coo_encoder_if.slave  bus
);
  localparam int ROW_W = $clog2(N);
  localparam int IDX_W = $clog2(MAX_NNZ);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]       r_state;
  logic [8*N-1:0]   r_row_data;
  logic [N-1:0]     r_mask;
  logic [ROW_W-1:0] r_row;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_nnz_count;
  logic             r_overflow;

  logic [N-1:0]     w_in_mask;
  logic [N-1:0]     w_mask_next;
  logic [ROW_W-1:0] w_col;
  logic             w_emit;
  logic             w_adv;
  logic             w_last_row;

  // Sign bit ignored so that -0 is treated as zero.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign w_in_mask[gi] = |bus.in_row[8*gi +: 7];
    end
  endgenerate

  always_comb begin
    w_col = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (r_mask[j]) begin
        w_col = ROW_W'(j);
      end
    end
  end

  assign w_mask_next = r_mask & (r_mask - N'(1));
  assign w_emit      = r_cnt < CNT_W'(MAX_NNZ);
  // Once the table is full, remaining nonzeros drain one per cycle without a handshake.
  assign w_adv       = (r_state == ST_SCAN) && (bus.out_ready || !w_emit);
  assign w_last_row  = r_row == ROW_W'(N - 1);

  assign bus.in_ready  = (r_state == ST_ACCEPT) && !rst;
  assign bus.out_valid = (r_state == ST_SCAN) && w_emit;
  assign bus.out_data  = r_row_data[{w_col, 3'b000} +: 8];
  assign bus.out_row   = r_row;
  assign bus.out_col   = w_col;
  assign bus.out_idx   = r_cnt[IDX_W-1:0];
  assign bus.done      = r_state == ST_DONE;
  assign bus.nnz_count = (r_state == ST_DONE) ? r_cnt : r_nnz_count;
  assign bus.overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCEPT;
      r_row_data  <= '0;
      r_mask      <= '0;
      r_row       <= '0;
      r_cnt       <= '0;
      r_nnz_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (bus.in_valid) begin
            r_row_data <= bus.in_row;
            r_mask     <= w_in_mask;
            // Status of the previous matrix is held until its successor starts.
            if (r_row == '0) begin
              r_overflow  <= 1'b0;
              r_nnz_count <= '0;
            end
            if (|w_in_mask) begin
              r_state <= ST_SCAN;
            end else if (w_last_row) begin
              r_state <= ST_DONE;
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end
        ST_SCAN: begin
          if (w_adv) begin
            r_mask <= w_mask_next;
            if (w_emit) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_overflow <= 1'b1;
            end
            if (w_mask_next == '0) begin
              if (w_last_row) begin
                r_state <= ST_DONE;
              end else begin
                r_row   <= r_row + ROW_W'(1);
                r_state <= ST_ACCEPT;
              end
            end
          end
        end
        ST_DONE: begin
          r_nnz_count <= r_cnt;
          r_row       <= '0;
          r_cnt       <= '0;
          r_mask      <= '0;
          r_state     <= ST_ACCEPT;
        end
        default: begin
          r_state <= ST_ACCEPT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dense_to_coo_encoder.sv
// Directed and randomized bench for dense_to_coo_encoder against a row-major COO reference model.
module tb_dense_to_coo_encoder;
  localparam int N       = 8;
  localparam int MAX_NNZ = 32;
  localparam int ROW_W   = $clog2(N);
  localparam int IDX_W   = $clog2(MAX_NNZ);

  typedef struct packed {
    logic [7:0]       data;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] col;
    logic [IDX_W-1:0] idx;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dense_to_coo_encoder_if #(.N(N), .MAX_NNZ(MAX_NNZ)) bus ();

  dense_to_coo_encoder #(.N(N), .MAX_NNZ(MAX_NNZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  entry_t exp_q[$];
  int     exp_nnz = 0;
  logic   exp_ovf = 1'b0;
  int     done_cnt = 0;
  int     cyc = 0;
  int     last_evt = 0;
  int     rdy_mode = 0;
  logic [7:0] mat [N][N];
  logic   prev_stall = 1'b0;
  entry_t prev_ent;
  entry_t cur;
  entry_t exp_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: scan the matrix row-major, keep nonzeros up to the table capacity.
  task automatic build_expect();
    int total;
    total = 0;
    exp_q.delete();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (mat[r][c][6:0] != 7'd0) begin
          if (total < MAX_NNZ) begin
            exp_q.push_back('{data: mat[r][c], row: ROW_W'(r), col: ROW_W'(c), idx: IDX_W'(total)});
          end
          total++;
        end
      end
    end
    exp_nnz = (total > MAX_NNZ) ? MAX_NNZ : total;
    exp_ovf = total > MAX_NNZ;
  endtask

  function automatic logic [8*N-1:0] pack_row(input int r);
    logic [8*N-1:0] v;
    for (int c = 0; c < N; c++) begin
      v[8*c +: 8] = mat[r][c];
    end
    return v;
  endfunction

  task automatic clear_mat();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        mat[r][c] = 8'h00;
      end
    end
  endtask

  task automatic load_ref();
    clear_mat();
    mat[0][0] = 8'h38; mat[0][1] = 8'h40; mat[0][2] = 8'h48;
    mat[1][0] = 8'h50; mat[1][1] = 8'h58; mat[1][2] = 8'h60;
    mat[2][0] = 8'h68; mat[2][1] = 8'h70;
  endtask

  // Called in the phase just after a rising edge; returns in the same phase.
  task automatic send_row(input int r, input int gap_max);
    bit accepted;
    int t;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_row   = pack_row(r);
    accepted = 1'b0;
    t = 0;
    while (!accepted && t < 500) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!accepted) check_eq("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_row   = {$urandom, $urandom};
  endtask

  task automatic send_matrix(input string name, input int gap_max);
    int start;
    int t;
    build_expect();
    $display("matrix %s: expecting %0d entries, overflow=%0d", name, exp_nnz, exp_ovf);
    start = done_cnt;
    for (int r = 0; r < N; r++) begin
      send_row(r, gap_max);
    end
    t = 0;
    while (done_cnt == start && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == start) check_eq("done_timeout", 32'd0, 32'd1);
    repeat (2) begin
      @(negedge clk);
      check_eq("nnz_hold", 32'(bus.nnz_count), 32'(exp_nnz));
      check_eq("ovf_hold", 32'(bus.overflow), 32'(exp_ovf));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int pc;
    pc = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (pc % 4 == 0) || (pc % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      pc++;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {bus.out_data, bus.out_row, bus.out_col, bus.out_idx};
        if (prev_stall) check_eq("hold_stall", {12'd0, bus.out_valid, cur}, {12'd0, 1'b1, prev_ent});
        if (bus.out_valid) check_eq("in_ready_scan", 32'(bus.in_ready), 32'd0);
        if (bus.in_valid && bus.in_ready) last_evt = cyc;
        if (bus.out_valid && bus.out_ready) begin
          last_evt = cyc;
          $display("entry idx=%0d row=%0d col=%0d data=0x%02h", bus.out_idx, bus.out_row, bus.out_col, bus.out_data);
          if (exp_q.size() == 0) begin
            check_eq("extra_entry", 32'd1, 32'd0);
          end else begin
            exp_e = exp_q.pop_front();
            check_eq("entry", 32'(cur), 32'(exp_e));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_ent   = cur;
        if (bus.done) begin
          done_cnt++;
          $display("done nnz_count=%0d overflow=%0d", bus.nnz_count, bus.overflow);
          check_eq("nnz_count", 32'(bus.nnz_count), 32'(exp_nnz));
          check_eq("overflow", 32'(bus.overflow), 32'(exp_ovf));
          check_eq("missing_entries", 32'(exp_q.size()), 32'd0);
          if (!exp_ovf) check_eq("done_latency", 32'(cyc - last_evt), 32'd1);
        end
      end
    end
  end

  initial begin
    int t;
    int dsnap;
    int p;
    bus.in_valid = 1'b0;
    bus.in_row   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_nnz", 32'(bus.nnz_count), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    rdy_mode = 0;
    load_ref();
    send_matrix("reference", 0);

    clear_mat();
    mat[0][0] = 8'h80; mat[0][1] = 8'h7F; mat[0][2] = 8'h00; mat[0][3] = 8'hB8;
    send_matrix("signed_zero_nan", 0);

    rdy_mode = 1;
    load_ref();
    send_matrix("backpressure", 1);

    rdy_mode = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        mat[r][c] = 8'h38;
      end
    end
    send_matrix("overflow", 0);
    clear_mat();
    send_matrix("all_zero", 0);

    // Reset while row 1's second entry is on the output.
    load_ref();
    build_expect();
    dsnap = done_cnt;
    send_row(0, 0);
    send_row(1, 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.out_valid && bus.out_idx == IDX_W'(4)) && t < 100);
    check_eq("reach_idx4", 32'(bus.out_idx), 32'd4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_fields", 32'({bus.out_data, bus.out_row, bus.out_col, bus.out_idx}), 32'd0);
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    check_eq("midrst_nnz", 32'(bus.nnz_count), 32'd0);
    check_eq("midrst_ovf", 32'(bus.overflow), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("no_done_on_rst", 32'(done_cnt), 32'(dsnap));
    check_eq("in_ready_after_midrst", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    send_matrix("after_reset", 0);

    rdy_mode = 2;
    for (int k = 0; k < 8; k++) begin
      p = (k == 5) ? 90 : $urandom_range(0, 60);
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if ($urandom_range(0, 99) < p) mat[r][c] = 8'($urandom);
          else mat[r][c] = $urandom_range(0, 1) ? 8'h80 : 8'h00;
        end
      end
      send_matrix($sformatf("random%0d", k), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
